multiplier_srcsa_dff: RTL and testbench



---
 rtl/multiplier_srcsa_dff.sv | 57 +++++
 tb/tb_multiplier_srcsa_dff.sv | 108 ++++++++++
 2 files changed

// File: rtl/multiplier_srcsa_dff.sv
// multiplier_srcsa_dff: registered unsigned WIDTHxWIDTH carry-save array multiplier with ripple-carry final adder
//   clk  - rising-edge clock
//   rstn - asynchronous active-low reset, clears mul
//   a, b - unsigned operands, sampled on every rising edge
//   mul  - registered exact product a*b, one edge of latency
module multiplier_srcsa_dff #(
  parameter int WIDTH = 28
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   mul
);
  logic [WIDTH-1:0]   w_s;
  logic [WIDTH-2:0]   w_c;
  logic [WIDTH-1:0]   w_lo;
  logic [WIDTH-1:0]   w_hi;
  logic [2*WIDTH-1:0] r_mul;
  // Each CSA row shifts the previous sum vector down one column so its LSB retires
  // as a product bit. The top column only ever sees its partial product, so the
  // carry vector is WIDTH-1 bits and the final ripple adder's carry-out is bit 2*WIDTH-1.
  always_comb begin
    logic x, y, z, cy;
    w_s  = a & {WIDTH{b[0]}};
    w_c  = '0;
    w_lo = '0;
    w_hi = '0;
    x    = 1'b0;
    y    = 1'b0;
    z    = 1'b0;
    cy   = 1'b0;
    w_lo[0] = w_s[0];
    for (int i = 1; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH-1; j++) begin
        x = w_s[j+1];
        y = w_c[j];
        z = a[j] & b[i];
        w_s[j] = x ^ y ^ z;
        w_c[j] = (x & y) | (x & z) | (y & z);
      end
      w_s[WIDTH-1] = a[WIDTH-1] & b[i];
      w_lo[i] = w_s[0];
    end
    for (int j = 0; j < WIDTH-1; j++) begin
      x = w_s[j+1];
      y = w_c[j];
      w_hi[j] = x ^ y ^ cy;
      cy = (x & y) | (x & cy) | (y & cy);
    end
    w_hi[WIDTH-1] = cy;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_mul <= '0;
    else r_mul <= {w_hi, w_lo};
  assign mul = r_mul;
endmodule

// File: tb/tb_multiplier_srcsa_dff.sv
// tb_multiplier_srcsa_dff: directed, table-driven and streaming checks of the registered multiplier
module tb_multiplier_srcsa_dff;
  logic        clk = 1'b0;
  logic        rstn;
  logic [27:0] a, b;
  logic [55:0] mul;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [27:0] a;
    logic [27:0] b;
    logic [55:0] p;
  } vec_t;
  vec_t vt[10];
  multiplier_srcsa_dff #(.WIDTH(28)) dut (.clk(clk), .rstn(rstn), .a(a), .b(b), .mul(mul));
  always #5 clk = ~clk;
  function automatic logic [55:0] prod(input logic [27:0] x, input logic [27:0] y);
    return {28'd0, x} * {28'd0, y};
  endfunction
  task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic apply(input logic [27:0] x, input logic [27:0] y);
    @(negedge clk);
    a = x;
    b = y;
    @(posedge clk);
    #2;
  endtask
  task automatic stream(input int n);
    logic [27:0] x, y;
    for (int i = 0; i < n; i++) begin
      x = 28'($urandom);
      y = 28'($urandom);
      apply(x, y);
      check($sformatf("stream%0d", i), mul, prod(x, y));
    end
  endtask
  initial begin
    vt[0] = '{28'h0000003, 28'h0000005, 56'h0000000000000F};
    vt[1] = '{28'h0000000, 28'hFFFFFFF, 56'h00000000000000};
    vt[2] = '{28'hFFFFFFF, 28'hFFFFFFF, 56'hFFFFFFE0000001};
    vt[3] = '{28'h8000000, 28'h0000002, 56'h00000010000000};
    vt[4] = '{28'h1234567, 28'h0000010, 56'h00000012345670};
    vt[5] = '{28'h0000001, 28'h0000001, 56'h00000000000001};
    vt[6] = '{28'hFFFFFFF, 28'h0000001, 56'h0000000FFFFFFF};
    vt[7] = '{28'h8000000, 28'h8000000, 56'h40000000000000};
    vt[8] = '{28'hFFFFFFF, 28'h0000002, 56'h0000001FFFFFFE};
    vt[9] = '{28'h0000100, 28'h0000100, 56'h00000000010000};
    rstn = 1'b1;
    a = 28'h3;
    b = 28'h5;
    @(posedge clk);
    #2;
    check("pre_reset_load", mul, 56'hF);
    #3;
    rstn = 1'b0;
    #1;
    check("async_clear", mul, 56'h0);
    a = 28'h1234567;
    b = 28'h89ABCDE;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check($sformatf("reset_hold%0d", i), mul, 56'h0);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #2;
    check("first_after_release", mul, prod(28'h1234567, 28'h89ABCDE));
    for (int i = 0; i < 10; i++) begin
      apply(vt[i].a, vt[i].b);
      check($sformatf("vec%0d", i), mul, vt[i].p);
    end
    @(negedge clk);
    a = 28'h1;
    b = 28'h1;
    #2;
    a = 28'h7;
    b = 28'h9;
    @(posedge clk);
    #2;
    check("mid_cycle_change", mul, 56'd63);
    stream(50);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_stream_clear", mul, 56'h0);
    @(posedge clk);
    #2;
    check("mid_stream_hold", mul, 56'h0);
    @(negedge clk);
    rstn = 1'b1;
    a = 28'hABCDEF1;
    b = 28'h7654321;
    @(posedge clk);
    #2;
    check("mid_stream_release", mul, prod(28'hABCDEF1, 28'h7654321));
    stream(50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
